div_requester: RTL and testbench

//  Initiator for the sequential divider's sen1/sen2/done interface. Accepts operand

---
 rtl/div_pkg.sv | 15 +
 rtl/div_cnt_down.sv | 26 ++
 rtl/div_requester.sv | 124 ++++++++++++
 tb/tb_div_requester.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types for the divider requester: FSM state encoding and response error codes.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } div_state_e;

    localparam logic [1:0] RSP_OK   = 2'b00;
    localparam logic [1:0] RSP_DIV0 = 2'b01;
    localparam logic [1:0] RSP_TMO  = 2'b10;

endpackage

// File: rtl/div_cnt_down.sv
// Loadable down-counter that saturates at zero and flags when it sits at zero.
module div_cnt_down #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/div_requester.sv
// Initiator for the sequential divider's sen1/sen2/done handshake, with
// divide-by-zero bypass and a watchdog on hung divides.
module div_requester
    import div_pkg::*;
#(
    parameter int N       = 20,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 4 * N + 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_dividend,
    input  logic [N-1:0] req_divisor,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_q,
    output logic [1:0]   rsp_err,
    output logic [N-1:0] div_dividend,
    output logic [N-1:0] div_divisor,
    output logic         div_sen1,
    output logic         div_sen2,
    input  logic [N-1:0] div_q,
    input  logic         div_done,
    output logic         busy,
    output div_state_e   fsm_state
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(GAP + 1);

    // Handshake rules: a request transfers on an edge where req_valid && req_ready;
    // a response transfers on an edge where rsp_valid && rsp_ready. rsp_valid and
    // rsp_q/rsp_err hold steady until that transfer.
    div_state_e state;
    div_state_e state_nxt;

    logic accept;
    logic div_zero;
    logic run_exit;
    logic tmo_zero;
    logic gap_zero;

    assign accept   = req_valid && req_ready;
    assign div_zero = (req_divisor == '0);
    assign run_exit = (state == ST_RUN) && (div_done || tmo_zero);
    assign fsm_state = state;

    // Loaded at accept, so it holds TIMEOUT during ARM and RUN lasts exactly
    // TIMEOUT cycles before the watchdog fires on the cycle it reads zero.
    div_cnt_down #(.W(TMO_W)) u_tmo_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (accept),
        .load_val (TMO_W'(TIMEOUT)),
        .zero     (tmo_zero)
    );

    div_cnt_down #(.W(GAP_W)) u_gap_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (run_exit),
        .load_val (GAP_W'(GAP)),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = div_zero ? ST_RESP : ST_ARM;
            ST_ARM:  state_nxt = ST_RUN;
            ST_RUN:  if (div_done || tmo_zero) state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Done wins over timeout when both land on the same edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            rsp_q        <= '0;
            rsp_err      <= RSP_OK;
        end else begin
            if (accept) begin
                div_dividend <= req_dividend;
                div_divisor  <= req_divisor;
                if (div_zero) begin
                    rsp_q   <= '1;
                    rsp_err <= RSP_DIV0;
                end
            end
            if (state == ST_RUN) begin
                if (div_done) begin
                    rsp_q   <= div_q;
                    rsp_err <= RSP_OK;
                end else if (tmo_zero) begin
                    rsp_q   <= '0;
                    rsp_err <= RSP_TMO;
                end
            end
        end
    end

    // req_ready is held low while reset is asserted so nothing is taken then.
    always_comb begin
        rsp_valid = (state == ST_RESP);
        div_sen1  = (state == ST_ARM) || (state == ST_RUN);
        div_sen2  = (state == ST_RUN);
        busy      = (state != ST_IDLE) || !gap_zero;
        req_ready = reset_n && (state == ST_IDLE) && gap_zero && !rsp_valid;
    end

endmodule

// File: tb/tb_div_requester.sv
// Directed bench for div_requester with a behavioural divider and a response scoreboard.
module tb_div_requester;
    import div_pkg::*;

    localparam int N       = 20;
    localparam int GAP     = 2;
    localparam int TIMEOUT = 88;
    localparam int LAT     = 5;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req_valid;
    logic         req_ready;
    logic [N-1:0] req_dividend;
    logic [N-1:0] req_divisor;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_q;
    logic [1:0]   rsp_err;
    logic [N-1:0] div_dividend;
    logic [N-1:0] div_divisor;
    logic         div_sen1;
    logic         div_sen2;
    logic [N-1:0] div_q;
    logic         div_done;
    logic         busy;
    div_state_e   fsm_state;

    int errors = 0;
    int checks = 0;
    logic [N+1:0] exp_q[$];

    logic model_hang = 1'b0;
    int   mcnt = 0;
    int   last_run = 0;

    div_requester #(.N(N), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_q        (rsp_q),
        .rsp_err      (rsp_err),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_sen1     (div_sen1),
        .div_sen2     (div_sen2),
        .div_q        (div_q),
        .div_done     (div_done),
        .busy         (busy),
        .fsm_state    (fsm_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural divider: raises done LAT cycles into sen2, holds it until sens drop.
    always @(posedge clk) begin
        #1;
        if (!div_sen2 || model_hang) begin
            div_done = 1'b0;
            mcnt     = 0;
        end else if (mcnt == LAT) begin
            div_done = 1'b1;
            div_q    = (div_divisor != '0) ? div_dividend / div_divisor : '1;
        end else begin
            mcnt = mcnt + 1;
        end
    end

    // Protocol monitor on the divider side
    logic         prev_sen1 = 1'b0;
    logic         prev_sen2 = 1'b0;
    int           sen1_len = 0;
    int           low_len = 0;
    int           run_len = 0;
    bit           had_job = 0;
    logic [N-1:0] cap_dvd;
    logic [N-1:0] cap_dvs;

    always @(negedge clk) begin
        if (!reset_n) begin
            had_job  = 0;
            sen1_len = 0;
            low_len  = 0;
            run_len  = 0;
        end else begin
            if (div_sen1 && !prev_sen1) begin
                if (had_job) chk("gap_cycles_ge", 32'(low_len >= GAP + 1), 32'd1);
                had_job = 1;
                cap_dvd = div_dividend;
                cap_dvs = div_divisor;
            end else if (div_sen1) begin
                chk("dividend_stable", 32'(div_dividend), 32'(cap_dvd));
                chk("divisor_stable", 32'(div_divisor), 32'(cap_dvs));
            end
            if (div_sen2 && !prev_sen2) chk("sen1_lead", 32'(sen1_len), 32'd1);
            if (div_sen2 && !div_sen1) chk("sen2_without_sen1", 32'd1, 32'd0);
            sen1_len = div_sen1 ? sen1_len + 1 : 0;
            low_len  = div_sen1 ? 0 : low_len + 1;
            if (div_sen2) run_len = run_len + 1;
            else if (prev_sen2) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
        prev_sen1 = div_sen1;
        prev_sen2 = div_sen2;
    end

    // Scoreboard monitor: pops on every response transfer
    always @(negedge clk) begin
        logic [N+1:0] e;
        if (reset_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_q", 32'(rsp_q), 32'(e[N+1:2]));
                chk("rsp_err", 32'(rsp_err), 32'(e[1:0]));
                chk("sens_low_at_rsp", 32'({div_sen1, div_sen2}), 32'd0);
            end
        end
    end

    // Driver tasks
    task automatic send(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                        input logic [N-1:0] eq, input logic [1:0] ee, input bit push);
        bit acc;
        int n;
        if (push) exp_q.push_back({eq, ee});
        req_dividend = dvd;
        req_divisor  = dvs;
        req_valid    = 1'b1;
        acc = 0;
        n   = 0;
        while (!acc && n < 500) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            n++;
        end
        req_valid = 1'b0;
        if (!acc) chk("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || rsp_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) chk("rsp_wait_timeout", 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        reset_n      = 1'b0;
        req_valid    = 1'b0;
        req_dividend = '0;
        req_divisor  = '0;
        rsp_ready    = 1'b1;
        div_q        = '0;
        div_done     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_sens", 32'({div_sen1, div_sen2}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp", 32'({rsp_q, rsp_err}), 32'd0);
        chk("rst_operands", 32'({div_dividend, div_divisor} != '0), 32'd0);
        chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic divide
        send(20'd25, 20'd3, 20'd8, RSP_OK, 1);
        @(negedge clk);
        chk("sen1_after_accept", 32'({div_sen1, div_sen2}), 32'b10);
        chk("busy_in_arm", 32'(busy), 32'd1);
        wait_idle();

        // Back-to-back jobs
        send(20'd14400, 20'd7, 20'd2057, RSP_OK, 1);
        send(20'd14400, 20'd999, 20'd14, RSP_OK, 1);
        wait_idle();

        // Divide by zero
        send(20'd5, 20'd0, 20'hFFFFF, RSP_DIV0, 1);
        @(negedge clk);
        chk("div0_rsp_valid_next", 32'(rsp_valid), 32'd1);
        chk("div0_sens_low", 32'({div_sen1, div_sen2}), 32'd0);
        @(negedge clk);
        chk("div0_sens_low_after", 32'({div_sen1, div_sen2}), 32'd0);
        wait_idle();

        // Hung divider
        model_hang = 1'b1;
        send(20'd77, 20'd7, 20'd0, RSP_TMO, 1);
        wait_idle();
        chk("timeout_run_cycles", 32'(last_run), 32'(TIMEOUT));
        model_hang = 1'b0;

        // Consumer back-pressure
        rsp_ready = 1'b0;
        send(20'd100, 20'd10, 20'd10, RSP_OK, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 200);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_q", 32'(rsp_q), 32'd10);
            chk("hold_rsp_err", 32'(rsp_err), 32'(RSP_OK));
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        wait_idle();

        // Reset in the middle of RUN
        send(20'd25, 20'd3, 20'd0, RSP_OK, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!div_sen2 && n < 20);
        chk("reached_run", 32'(div_sen2), 32'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_sens", 32'({div_sen1, div_sen2}), 32'd0);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        send(20'd25, 20'd3, 20'd8, RSP_OK, 1);
        wait_idle();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
